hazard_sequencer: RTL and testbench

Pipeline sequencing controller for the five-stage forwarding pipeline. It detects load-use and branch-operand hazards and drives the `harzard` bubble input of the ID-stage decoder. It generates PC/IF-ID enables and flushes, forwarding selects for the EX ALU operands and the ID branch comparator, and the terminate drain/halt sequence. It sits beside the pipeline registers and is the only source of stall, flush and halt.

---
 rtl/hazard_sequencer_pkg.sv | 23 ++
 rtl/forward_unit.sv | 42 ++++
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared encodings for the pipeline sequencing controller: forward selects,
// sequencer states and the register-match helper used by stall and forward logic.
package hazard_sequencer_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_DRAIN = 2'd1,
        SEQ_HALT  = 2'd2
    } seq_state_t;

    // $0 is hardwired zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational bypass selection for the EX ALU operands and the ID branch comparator.
module forward_unit
    import hazard_sequencer_pkg::*;
(
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wb_en,
    input  logic             mem_mem_r,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wb_en,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             fwd_id_a,
    output logic             fwd_id_b
);

    // Only an ALU result is available in EX/MEM; a load's data arrives in MEM/WB.
    logic mem_alu;
    assign mem_alu = mem_wb_en && !mem_mem_r;

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (mem_alu && reg_match(mem_rd, ex_rs)) begin
            fwd_a = FWD_EXMEM;
        end else if (wb_wb_en && reg_match(wb_rd, ex_rs)) begin
            fwd_a = FWD_MEMWB;
        end
        if (mem_alu && reg_match(mem_rd, ex_rt)) begin
            fwd_b = FWD_EXMEM;
        end else if (wb_wb_en && reg_match(wb_rd, ex_rt)) begin
            fwd_b = FWD_MEMWB;
        end
    end

    assign fwd_id_a = mem_alu && reg_match(mem_rd, rs_id);
    assign fwd_id_b = mem_alu && reg_match(mem_rd, rt_id);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use / branch-operand stalls, redirect flushes,
// terminate drain-and-halt sequence, and the stall-cycle counter.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             jump_taken,
    input  logic             terminate,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wb_en,
    input  logic             mem_mem_r,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wb_en,
    output logic             harzard,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             fwd_id_a,
    output logic             fwd_id_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    seq_state_t         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    logic             rs_dep_ex, rt_dep_ex, rs_dep_mem_ld, rt_dep_mem_ld;
    logic             lu, bs, run_stall;
    logic [FWD_W-1:0] fwd_a_raw, fwd_b_raw;
    logic             fwd_id_a_raw, fwd_id_b_raw;

    forward_unit u_forward_unit (
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .mem_rd    (mem_rd),
        .mem_wb_en (mem_wb_en),
        .mem_mem_r (mem_mem_r),
        .wb_rd     (wb_rd),
        .wb_wb_en  (wb_wb_en),
        .fwd_a     (fwd_a_raw),
        .fwd_b     (fwd_b_raw),
        .fwd_id_a  (fwd_id_a_raw),
        .fwd_id_b  (fwd_id_b_raw)
    );

    // Dependencies of the ID instruction's used sources on EX and on a load in MEM.
    assign rs_dep_ex     = id_uses_rs && ex_wb_en && reg_match(ex_rd, rs_id);
    assign rt_dep_ex     = id_uses_rt && ex_wb_en && reg_match(ex_rd, rt_id);
    assign rs_dep_mem_ld = id_uses_rs && mem_wb_en && mem_mem_r && reg_match(mem_rd, rs_id);
    assign rt_dep_mem_ld = id_uses_rt && mem_wb_en && mem_mem_r && reg_match(mem_rd, rt_id);

    assign lu        = ex_mem_r && (rs_dep_ex || rt_dep_ex);
    assign bs        = id_is_branch && (rs_dep_ex || rt_dep_ex || rs_dep_mem_ld || rt_dep_mem_ld);
    assign run_stall = (state == SEQ_RUN) && (lu || bs);

    always_comb begin
        harzard     = 1'b0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        if (rst) begin
            harzard     = 1'b1;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
        end else begin
            case (state)
                SEQ_RUN: begin
                    // Stall wins: redirect/terminate operands are stale this cycle.
                    if (run_stall) begin
                        harzard  = 1'b1;
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                    end else if (terminate) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end else if (branch_taken || jump_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
                default: begin
                    harzard     = 1'b1;
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    if_id_flush = 1'b1;
                end
            endcase
        end
    end

    assign fwd_a       = rst ? FWD_REG : fwd_a_raw;
    assign fwd_b       = rst ? FWD_REG : fwd_b_raw;
    assign fwd_id_a    = !rst && fwd_id_a_raw;
    assign fwd_id_b    = !rst && fwd_id_b_raw;
    assign halted      = !rst && (state == SEQ_HALT);
    assign stall_count = rst ? '0 : stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                SEQ_RUN: begin
                    if (run_stall && (stall_cnt != '1)) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                    if (!run_stall && terminate) begin
                        state     <= SEQ_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                SEQ_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= SEQ_HALT;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                SEQ_HALT: state <= SEQ_HALT;
                default:  state <= SEQ_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: combinational vector table plus
// multi-cycle sequences for stalls, terminate/drain/halt, reset and saturation.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_id, rt_id, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, id_is_branch, branch_taken, jump_taken, terminate;
    logic       ex_wb_en, ex_mem_r, mem_wb_en, mem_mem_r, wb_wb_en;

    logic        harzard, pc_en, if_id_en, if_id_flush, fwd_id_a, fwd_id_b, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count;

    logic       s_harzard, s_pc_en, s_if_id_en, s_if_id_flush, s_fwd_id_a, s_fwd_id_b, s_halted;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [1:0] s_stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .terminate(terminate),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r),
        .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_mem_r(mem_mem_r),
        .wb_rd(wb_rd), .wb_wb_en(wb_wb_en),
        .harzard(harzard), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
        .halted(halted), .stall_count(stall_count)
    );

    hazard_sequencer #(.DRAIN_CYCLES(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .terminate(terminate),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r),
        .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_mem_r(mem_mem_r),
        .wb_rd(wb_rd), .wb_wb_en(wb_wb_en),
        .harzard(s_harzard), .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_id_a(s_fwd_id_a), .fwd_id_b(s_fwd_id_b),
        .halted(s_halted), .stall_count(s_stall_count)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       ur, ut, br, bt, jt;
        logic [4:0] exrs, exrt, exrd;
        logic       exwb, exmr;
        logic [4:0] memrd;
        logic       memwb, memmr;
        logic [4:0] wbrd;
        logic       wbwb;
        logic       e_hz, e_pc, e_ifen, e_fl;
        logic [1:0] e_fa, e_fb;
        logic       e_fia, e_fib;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_id = 0; rt_id = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
        branch_taken = 0; jump_taken = 0; terminate = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_wb_en = 0; ex_mem_r = 0;
        mem_rd = 0; mem_wb_en = 0; mem_mem_r = 0; wb_rd = 0; wb_wb_en = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs_id = v.rs; rt_id = v.rt; id_uses_rs = v.ur; id_uses_rt = v.ut;
        id_is_branch = v.br; branch_taken = v.bt; jump_taken = v.jt; terminate = 0;
        ex_rs = v.exrs; ex_rt = v.exrt; ex_rd = v.exrd; ex_wb_en = v.exwb; ex_mem_r = v.exmr;
        mem_rd = v.memrd; mem_wb_en = v.memwb; mem_mem_r = v.memmr;
        wb_rd = v.wbrd; wb_wb_en = v.wbwb;
    endtask

    // EX load of rd, ID reads rs (ALU op, not a branch).
    task automatic set_load_use(input logic [4:0] r);
        idle();
        rs_id = r; id_uses_rs = 1; ex_rd = r; ex_wb_en = 1; ex_mem_r = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [9:0] ctl();
        return {harzard, pc_en, if_id_en, if_id_flush, fwd_a, fwd_b, fwd_id_a, fwd_id_b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          rs rt ur ut br bt jt exrs exrt exrd exwb exmr memrd memwb memmr wbrd wbwb hz pc ifen fl fa fb fia fib
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{2, 3, 1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{4, 2, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 0, 3, 1, 0, 4, 1, 0, 1, 1, 0, 2, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 7, 1, 0, 7, 1, 0, 1, 1, 0, 2, 2, 0, 0};
        vecs[7]  = '{7, 0, 1, 0, 0, 0, 0, 7, 9, 0, 0, 0, 7, 1, 1, 7, 1, 0, 1, 1, 0, 1, 0, 0, 0};
        vecs[8]  = '{5, 6, 1, 1, 1, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{5, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[10] = '{5, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};

        // Reset state, with forwarding-matching inputs present
        rst = 1; idle();
        ex_rs = 3; mem_rd = 3; mem_wb_en = 1; rs_id = 3;
        @(negedge clk); #1;
        check("reset_ctl", 64'(ctl()), 64'(10'b1001_00_00_0_0));
        check("reset_halted_count", 64'({halted, stall_count}), 64'd0);
        @(negedge clk);
        rst = 0; idle();

        // Combinational vector table (idle inputs restored before each edge)
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), 64'(ctl()),
                  64'({vecs[i].e_hz, vecs[i].e_pc, vecs[i].e_ifen, vecs[i].e_fl,
                       vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_fia, vecs[i].e_fib}));
            #1 idle();
        end
        check("vec_count_unchanged", 64'(stall_count), 64'd0);

        // Load-use: one stall, then MEM/WB forward to the dependent ALU op
        do_reset();
        @(negedge clk); set_load_use(5'd2); #1;
        check("lu_stall", 64'({harzard, pc_en, stall_count}), 64'({1'b1, 1'b0, 32'd0}));
        @(negedge clk); idle();
        rs_id = 2; id_uses_rs = 1; mem_rd = 2; mem_wb_en = 1; mem_mem_r = 1; #1;
        check("lu_release", 64'({harzard, pc_en, stall_count}), 64'({1'b0, 1'b1, 32'd1}));
        @(negedge clk); idle();
        ex_rs = 2; wb_rd = 2; wb_wb_en = 1; #1;
        check("lu_fwd_a", 64'(fwd_a), 64'd1);

        // Branch on a load: two stalls with branch_taken ignored, then redirect
        do_reset();
        @(negedge clk); idle();
        rs_id = 5; rt_id = 6; id_uses_rs = 1; id_uses_rt = 1; id_is_branch = 1; branch_taken = 1;
        ex_rd = 5; ex_wb_en = 1; ex_mem_r = 1; #1;
        check("br_ld_stall1", 64'({harzard, pc_en, if_id_flush}), 64'(3'b100));
        @(negedge clk);
        ex_rd = 0; ex_wb_en = 0; ex_mem_r = 0; mem_rd = 5; mem_wb_en = 1; mem_mem_r = 1; #1;
        check("br_ld_stall2", 64'({harzard, pc_en, if_id_flush, stall_count}), 64'({3'b100, 32'd1}));
        @(negedge clk);
        mem_rd = 0; mem_wb_en = 0; mem_mem_r = 0; wb_rd = 5; wb_wb_en = 1; #1;
        check("br_ld_redirect", 64'({harzard, pc_en, if_id_flush, stall_count}), 64'({3'b011, 32'd2}));
        #1 idle();

        // Terminate (with simultaneous redirect): drain 3 cycles, then halt
        do_reset();
        @(negedge clk); idle(); terminate = 1; branch_taken = 1; #1;
        check("term_accept", 64'({harzard, pc_en, if_id_flush, halted}), 64'(4'b0010));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); #1;
            check($sformatf("drain%0d", k), 64'({harzard, pc_en, if_id_flush, halted}), 64'(4'b1010));
        end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk); set_load_use(5'd4); #1;
            check($sformatf("halted%0d", k), 64'({harzard, pc_en, if_id_flush, halted}), 64'(4'b1011));
        end
        @(negedge clk); idle(); #1;
        check("halt_no_count", 64'(stall_count), 64'd0);

        // Reset during DRAIN returns to RUN and clears the count
        do_reset();
        @(negedge clk); set_load_use(5'd3);
        @(negedge clk); idle(); terminate = 1;
        @(negedge clk); idle();
        @(negedge clk); #1;
        check("pre_rst_drain", 64'({halted, harzard, stall_count}), 64'({2'b01, 32'd1}));
        rst = 1; #1;
        check("rst_in_drain", 64'({halted, pc_en, stall_count}), 64'd0);
        @(negedge clk); rst = 0; #1;
        check("run_after_rst", 64'({halted, harzard, pc_en, if_id_flush, stall_count}), 64'({4'b0010, 32'd0}));

        // Terminate during a load-use stall is not accepted
        do_reset();
        @(negedge clk); set_load_use(5'd8); terminate = 1; #1;
        check("term_in_stall", 64'({harzard, pc_en, if_id_flush}), 64'(3'b100));
        repeat (5) begin
            @(negedge clk); idle();
        end
        #1;
        check("term_rejected", 64'({halted, harzard, pc_en, stall_count}), 64'({3'b001, 32'd1}));

        // Stall counter saturation on the 2-bit instance
        do_reset();
        repeat (5) begin
            @(negedge clk); set_load_use(5'd1);
        end
        @(negedge clk); idle(); #1;
        check("sat_small", 64'(s_stall_count), 64'd3);
        check("sat_wide", 64'(stall_count), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
